// File: rtl/rhs_pkg.sv
// rtl/rhs_pkg.sv - shared command encodings, sequencer states and pipeline tag type
package rhs_pkg;

  localparam logic [31:0] CMD_CLEAR     = 32'h6A00_0000;
  localparam logic [31:0] CMD_CALIBRATE = 32'h5500_0000;
  localparam logic [31:0] CMD_DUMMY     = 32'hE800_0000;
  localparam int          PIPE_DEPTH    = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_CALIB,
    ST_CAL_DUMMY,
    ST_RUN,
    ST_WAIT,
    ST_HALT
  } state_e;

  typedef struct packed {
    logic       valid;
    logic [3:0] ch;
  } pipe_tag_t;

  function automatic logic [31:0] cmd_convert(input logic [3:0] ch);
    return {10'b0, 2'b00, ch, 16'h0000};
  endfunction

endpackage

// File: rtl/rhs_pipe_tracker.sv
// rtl/rhs_pipe_tracker.sv - tracks which conversion the chip's delayed result belongs to
module rhs_pipe_tracker
  import rhs_pkg::*;
(
  input  logic      clk_i,
  input  logic      rst_i,
  input  logic      flush_i,
  input  logic      adv_i,
  input  pipe_tag_t tag_i,
  output pipe_tag_t tag_o
);

  pipe_tag_t stage_q [PIPE_DEPTH];

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      for (int i = 0; i < PIPE_DEPTH; i++) stage_q[i] <= '0;
    end else if (adv_i) begin
      stage_q[0] <= tag_i;
      for (int i = 1; i < PIPE_DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  // Oldest entry is the owner of the word arriving with the current spi_done.
  assign tag_o = stage_q[PIPE_DEPTH-1];

endmodule

// File: rtl/rhs_cmd_sequencer.sv
// rtl/rhs_cmd_sequencer.sv - RHS chip command sequencer: calibrate, then round-robin convert
module rhs_cmd_sequencer
  import rhs_pkg::*;
#(
  parameter int NUM_CH      = 16,
  parameter int CAL_DUMMIES = 9,
  parameter int TIMEOUT     = 1023
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        enable_i,
  output logic        spi_start_o,
  output logic [31:0] spi_cmd_o,
  input  logic        spi_done_i,
  input  logic [31:0] spi_rx_i,
  output logic        sample_valid_o,
  output logic [3:0]  sample_ch_o,
  output logic [15:0] sample_data_o,
  output logic        frame_done_o,
  output logic        calibrating_o,
  output logic        timeout_err_o
);

  localparam int         TW      = $clog2(TIMEOUT + 2);
  localparam int         DW      = $clog2(CAL_DUMMIES + 2);
  localparam logic [3:0] LAST_CH = 4'(NUM_CH - 1);

  state_e        state_q, src_q;
  logic          spi_start_q, sample_valid_q, frame_done_q, calibrating_q, timeout_err_q;
  logic          need_low_q, halt_cnt_q;
  logic [31:0]   spi_cmd_q, cmd_d;
  logic [3:0]    ch_q, sample_ch_q;
  logic [15:0]   sample_data_q;
  logic [TW-1:0] wait_cnt_q;
  logic [DW-1:0] dum_cnt_q;
  pipe_tag_t     tag_q, tag_d, pipe_tag;
  logic          pipe_adv, timeout_hit;
  logic          unused_rx;

  assign unused_rx   = ^spi_rx_i[31:16];
  assign pipe_adv    = (state_q == ST_WAIT) && spi_done_i;
  assign timeout_hit = (state_q == ST_WAIT) && !spi_done_i && (wait_cnt_q == TW'(TIMEOUT));

  rhs_pipe_tracker u_pipe (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .flush_i(timeout_hit),
    .adv_i  (pipe_adv),
    .tag_i  (tag_q),
    .tag_o  (pipe_tag)
  );

  always_comb begin
    cmd_d = CMD_DUMMY;
    tag_d = '0;
    unique case (state_q)
      ST_CLEAR: cmd_d = CMD_CLEAR;
      ST_CALIB: cmd_d = CMD_CALIBRATE;
      ST_RUN: begin
        cmd_d = cmd_convert(ch_q);
        tag_d = {1'b1, ch_q};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= ST_IDLE;
      src_q          <= ST_IDLE;
      spi_start_q    <= 1'b0;
      spi_cmd_q      <= '0;
      sample_valid_q <= 1'b0;
      sample_ch_q    <= '0;
      sample_data_q  <= '0;
      frame_done_q   <= 1'b0;
      calibrating_q  <= 1'b0;
      timeout_err_q  <= 1'b0;
      need_low_q     <= 1'b0;
      halt_cnt_q     <= 1'b0;
      ch_q           <= '0;
      wait_cnt_q     <= '0;
      dum_cnt_q      <= '0;
      tag_q          <= '0;
    end else begin
      spi_start_q    <= 1'b0;
      sample_valid_q <= 1'b0;
      frame_done_q   <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (!enable_i) begin
            need_low_q <= 1'b0;
          end else if (!need_low_q) begin
            state_q       <= ST_CLEAR;
            calibrating_q <= 1'b1;
          end
        end
        ST_CLEAR, ST_CALIB, ST_CAL_DUMMY, ST_RUN, ST_HALT: begin
          // HALT always runs to completion; elsewhere a low enable aborts before issuing.
          if (!enable_i && state_q != ST_HALT) begin
            calibrating_q <= 1'b0;
            halt_cnt_q    <= 1'b0;
            state_q       <= (state_q == ST_CLEAR) ? ST_IDLE : ST_HALT;
          end else begin
            spi_start_q <= 1'b1;
            spi_cmd_q   <= cmd_d;
            tag_q       <= tag_d;
            src_q       <= state_q;
            wait_cnt_q  <= '0;
            state_q     <= ST_WAIT;
            if (state_q == ST_RUN) ch_q <= (ch_q == LAST_CH) ? 4'd0 : ch_q + 4'd1;
          end
        end
        ST_WAIT: begin
          if (spi_done_i) begin
            if (pipe_tag.valid) begin
              sample_valid_q <= 1'b1;
              sample_ch_q    <= pipe_tag.ch;
              sample_data_q  <= spi_rx_i[15:0];
              frame_done_q   <= (pipe_tag.ch == LAST_CH);
            end
            unique case (src_q)
              ST_CLEAR: state_q <= ST_CALIB;
              ST_CALIB: begin
                dum_cnt_q <= '0;
                ch_q      <= '0;
                if (CAL_DUMMIES == 0) begin
                  state_q       <= ST_RUN;
                  calibrating_q <= 1'b0;
                end else begin
                  state_q <= ST_CAL_DUMMY;
                end
              end
              ST_CAL_DUMMY: begin
                dum_cnt_q <= dum_cnt_q + DW'(1);
                if (dum_cnt_q == DW'(CAL_DUMMIES - 1)) begin
                  state_q       <= ST_RUN;
                  calibrating_q <= 1'b0;
                end else begin
                  state_q <= ST_CAL_DUMMY;
                end
              end
              ST_HALT: begin
                halt_cnt_q <= halt_cnt_q + 1'b1;
                state_q    <= halt_cnt_q ? ST_IDLE : ST_HALT;
              end
              default: state_q <= ST_RUN;
            endcase
          end else if (timeout_hit) begin
            timeout_err_q <= 1'b1;
            need_low_q    <= 1'b1;
            calibrating_q <= 1'b0;
            state_q       <= ST_IDLE;
          end else begin
            wait_cnt_q <= wait_cnt_q + TW'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign spi_start_o    = spi_start_q;
  assign spi_cmd_o      = spi_cmd_q;
  assign sample_valid_o = sample_valid_q;
  assign sample_ch_o    = sample_ch_q;
  assign sample_data_o  = sample_data_q;
  assign frame_done_o   = frame_done_q;
  assign calibrating_o  = calibrating_q;
  assign timeout_err_o  = timeout_err_q;

endmodule
